// File: rtl/line_mem_if.sv
// line_mem_if: level req/rw line handshake between the cache controller and line_mem_ctrl
interface line_mem_if;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdy;
    logic        busy;
    modport master (output req, rw, addr, wdata, input rdata, rdy, busy);
    modport slave  (input req, rw, addr, wdata, output rdata, rdy, busy);
endinterface

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: main-memory line read/write-back stage with programmable access latency
// Define REFRESH_EN to add a periodic refresh that blocks the array for REF_CYCLES cycles.
module line_mem_ctrl #(
    parameter int MEM_AW     = 14,
    parameter int LATENCY    = 4,
    parameter int REF_PERIOD = 64,
    parameter int REF_CYCLES = 4
) (
    input logic       clk,
    input logic       rst_n,
    line_mem_if.slave bus
);
    localparam int CW = 16;
`ifdef REFRESH_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, REFRESH} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
    state_t            st, nxt;
    logic [CW-1:0]     cnt;
    logic [MEM_AW-1:0] idx;
    logic              rw_l;
    logic [31:0]       wdata_l;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [2**MEM_AW];
    logic              commit;
    logic              ref_pend;
    assign commit    = st == ACCESS && cnt == '0;
    assign bus.rdy   = st == RESP;
    assign bus.busy  = st != IDLE;
    assign bus.rdata = rdata_q;
`ifdef REFRESH_EN
    localparam int RW = $clog2(REF_PERIOD + 1);
    logic [RW-1:0] ref_cnt;
    logic          unused_addr;
    assign unused_addr = ^bus.addr[1:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == RW'(REF_PERIOD - 1)) ? '0 : ref_cnt + 1'b1;
            if (ref_cnt == RW'(REF_PERIOD - 1)) ref_pend <= 1'b1;
            else if (st == IDLE) ref_pend <= 1'b0;
        end
`else
    logic unused_cfg;
    assign ref_pend   = 1'b0;
    assign unused_cfg = ^{bus.addr[1:0], REF_PERIOD[0], REF_CYCLES[0], ref_pend};
`endif
    // an X on req fails the equality test, so it is treated as no request
    always_comb begin
        nxt = st;
        case (st)
            IDLE: begin
`ifdef REFRESH_EN
                if (ref_pend) nxt = REFRESH;
                else if (bus.req == 1'b1) nxt = ACCESS;
`else
                if (bus.req == 1'b1) nxt = ACCESS;
`endif
            end
            ACCESS:  nxt = (cnt == '0) ? RESP : ACCESS;
            RESP:    nxt = IDLE;
`ifdef REFRESH_EN
            REFRESH: nxt = (cnt == '0) ? IDLE : REFRESH;
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st      <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            rw_l    <= 1'b0;
            wdata_l <= '0;
            rdata_q <= '0;
        end else begin
            st <= nxt;
            if (st == IDLE && nxt == ACCESS) begin
                idx     <= bus.addr[MEM_AW+1:2];
                rw_l    <= bus.rw;
                wdata_l <= bus.wdata;
                cnt     <= CW'(LATENCY - 1);
`ifdef REFRESH_EN
            end else if (st == IDLE && nxt == REFRESH) begin
                cnt <= CW'(REF_CYCLES - 1);
`endif
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && !rw_l) rdata_q <= mem[idx];
        end
    // no reset here so the array survives rst_n; commit is low while reset holds st in IDLE
    always_ff @(posedge clk)
        if (commit && rw_l) mem[idx] <= wdata_l;
    assert property (@(posedge clk) disable iff (!rst_n) st == IDLE |-> !$isunknown(bus.req));
endmodule
